// File: rtl/elevator_request_latch_pkg.sv
// elevator_pkg: motor action codes, direction type and default sizing shared with the controller
package elevator_pkg;
  localparam logic [1:0] AC_STOP = 2'b00;
  localparam logic [1:0] AC_UP   = 2'b01;
  localparam logic [1:0] AC_DOWN = 2'b10;
  localparam int DEF_NUM_FLOORS = 3;
  localparam int DEF_FLOOR_W    = 2;
  typedef enum logic [1:0] {DIR_IDLE, DIR_UP, DIR_DOWN} dir_t;
endpackage

// File: rtl/elevator_request_latch_if.sv
// elevator_request_latch_if: button/sensor inputs and latched request outputs of the front-end
interface elevator_request_latch_if #(
  parameter int NUM_FLOORS = elevator_pkg::DEF_NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::DEF_FLOOR_W
);
  logic [NUM_FLOORS-1:0] s, f, u, d;
  logic [1:0]            ac;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] cab_req, up_req, dn_req;
  logic [FLOOR_W-1:0]    cur_floor;
  logic                  req_above, req_below, req_here, sensor_err;
  modport master (
    output s, f, u, d, ac, door_open,
    input  cab_req, up_req, dn_req, cur_floor, req_above, req_below, req_here, sensor_err
  );
  modport slave (
    input  s, f, u, d, ac, door_open,
    output cab_req, up_req, dn_req, cur_floor, req_above, req_below, req_here, sensor_err
  );
endinterface

// File: rtl/elevator_request_latch_sync.sv
// sync_edge_detect: multi-flop synchroniser followed by a registered one-cycle rising-edge pulse
module sync_edge_detect #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_edge
);
  logic [STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]             r_prev, r_edge;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= '0;
      r_edge <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
      r_edge <= r_sync[STAGES-1] & ~r_prev;
    end
  end
  assign o_edge = r_edge;
endmodule

// File: rtl/elevator_request_latch.sv
// elevator_request_latch: latches button presses, tracks the current floor, clears served requests
module elevator_request_latch #(
  parameter int NUM_FLOORS  = elevator_pkg::DEF_NUM_FLOORS,
  parameter int FLOOR_W     = elevator_pkg::DEF_FLOOR_W,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  elevator_request_latch_if.slave bus
);
  import elevator_pkg::*;
  localparam int TOP = NUM_FLOORS - 1;
  localparam logic [NUM_FLOORS-1:0] UP_MASK = {1'b0, {TOP{1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DN_MASK = {{TOP{1'b1}}, 1'b0};
  logic [NUM_FLOORS-1:0] w_s, w_f, w_u, w_d, w_oh, w_any;
  logic [NUM_FLOORS-1:0] w_clr_cab, w_clr_up, w_clr_dn;
  logic [NUM_FLOORS-1:0] r_cab, r_up, r_dn;
  logic [FLOOR_W-1:0]    r_cur, w_idx;
  logic                  r_err, w_multi, w_above, w_below;
  dir_t                  r_dir, w_dir_nxt;
  sync_edge_detect #(.WIDTH(NUM_FLOORS), .STAGES(SYNC_STAGES)) u_sync_s (.clk(clk), .rst(rst), .i_d(bus.s), .o_edge(w_s));
  sync_edge_detect #(.WIDTH(NUM_FLOORS), .STAGES(SYNC_STAGES)) u_sync_f (.clk(clk), .rst(rst), .i_d(bus.f), .o_edge(w_f));
  sync_edge_detect #(.WIDTH(NUM_FLOORS), .STAGES(SYNC_STAGES)) u_sync_u (.clk(clk), .rst(rst), .i_d(bus.u), .o_edge(w_u));
  sync_edge_detect #(.WIDTH(NUM_FLOORS), .STAGES(SYNC_STAGES)) u_sync_d (.clk(clk), .rst(rst), .i_d(bus.d), .o_edge(w_d));
  assign w_oh    = NUM_FLOORS'(1) << r_cur;
  assign w_any   = r_cab | r_up | r_dn;
  assign w_multi = |(w_s & (w_s - NUM_FLOORS'(1)));
  // End floors serve the only possible hall direction regardless of travel direction
  assign w_clr_cab = bus.door_open ? w_oh : '0;
  assign w_clr_up  = (bus.door_open && (r_dir != DIR_DOWN || r_cur == '0)) ? w_oh : '0;
  assign w_clr_dn  = (bus.door_open && (r_dir != DIR_UP || int'(r_cur) == TOP)) ? w_oh : '0;
  assign w_dir_nxt = (bus.ac == AC_UP) ? DIR_UP : (bus.ac == AC_DOWN) ? DIR_DOWN : (|w_any) ? r_dir : DIR_IDLE;
  always_comb begin
    w_idx   = '0;
    w_above = 1'b0;
    w_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (w_s[i]) w_idx = FLOOR_W'(i);
      w_above = w_above | (w_any[i] & (i > int'(r_cur)));
      w_below = w_below | (w_any[i] & (i < int'(r_cur)));
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cab <= '0;
      r_up  <= '0;
      r_dn  <= '0;
      r_cur <= '0;
      r_err <= 1'b0;
      r_dir <= DIR_IDLE;
    end else begin
      r_cab <= (r_cab | w_f) & ~w_clr_cab;
      r_up  <= (r_up | (w_u & UP_MASK)) & ~w_clr_up;
      r_dn  <= (r_dn | (w_d & DN_MASK)) & ~w_clr_dn;
      r_dir <= w_dir_nxt;
      if (w_multi) r_err <= 1'b1;
      else if (|w_s) r_cur <= w_idx;
    end
  end
  assign bus.cab_req    = r_cab;
  assign bus.up_req     = r_up;
  assign bus.dn_req     = r_dn;
  assign bus.cur_floor  = r_cur;
  assign bus.sensor_err = r_err;
  assign bus.req_here   = |(w_any & w_oh);
  assign bus.req_above  = w_above;
  assign bus.req_below  = w_below;
endmodule

// File: tb/tb_elevator_request_latch.sv
// tb_elevator_request_latch: directed vectors with hand-computed expectations
module tb_elevator_request_latch;
  import elevator_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  elevator_request_latch_if #(.NUM_FLOORS(3), .FLOOR_W(2)) bus ();
  elevator_request_latch #(.NUM_FLOORS(3), .FLOOR_W(2), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    rst = 1'b1;
    bus.s = '0; bus.f = '0; bus.u = '0; bus.d = '0;
    bus.ac = AC_STOP; bus.door_open = 1'b0;
    #3;
    check("rst_cab", 32'(bus.cab_req), 0);
    check("rst_up", 32'(bus.up_req), 0);
    check("rst_dn", 32'(bus.dn_req), 0);
    check("rst_cur", 32'(bus.cur_floor), 0);
    check("rst_sum", {29'd0, bus.req_above, bus.req_below, bus.req_here}, 0);
    check("rst_err", 32'(bus.sensor_err), 0);
    #20 rst = 1'b0;
    tick(1);
    // hall up at floor 1: three-cycle latency
    bus.u = 3'b010;
    tick(1); bus.u = '0;
    tick(2);
    check("lat_early", 32'(bus.up_req), 0);
    tick(1);
    check("lat_up", 32'(bus.up_req), 32'b010);
    check("lat_above", 32'(bus.req_above), 1);
    check("lat_cur", 32'(bus.cur_floor), 0);
    // arrive at floor 1 with door open, idle: up request served
    bus.s = 3'b010; bus.door_open = 1'b1;
    tick(1); bus.s = '0;
    tick(3);
    check("arr1_cur", 32'(bus.cur_floor), 1);
    check("arr1_up", 32'(bus.up_req), 32'b010);
    check("arr1_here", 32'(bus.req_here), 1);
    tick(1);
    check("srv1_up", 32'(bus.up_req), 0);
    check("srv1_here", 32'(bus.req_here), 0);
    bus.door_open = 1'b0;
    // going up: cabin 0 and hall down 2
    bus.ac = AC_UP; bus.f = 3'b001; bus.d = 3'b100;
    tick(1); bus.f = '0; bus.d = '0;
    tick(3);
    check("up_cab", 32'(bus.cab_req), 32'b001);
    check("up_dn", 32'(bus.dn_req), 32'b100);
    check("up_above", 32'(bus.req_above), 1);
    check("up_below", 32'(bus.req_below), 1);
    bus.s = 3'b100; bus.door_open = 1'b1;
    tick(1); bus.s = '0;
    tick(3);
    check("arr2_cur", 32'(bus.cur_floor), 2);
    check("arr2_dn", 32'(bus.dn_req), 32'b100);
    tick(1);
    check("top_dn_clr", 32'(bus.dn_req), 0);
    check("top_cab", 32'(bus.cab_req), 32'b001);
    check("top_below", 32'(bus.req_below), 1);
    // down to floor 0, door stays open
    bus.ac = AC_STOP; bus.s = 3'b001;
    tick(1); bus.s = '0;
    tick(3);
    check("arr0_cur", 32'(bus.cur_floor), 0);
    tick(1);
    check("arr0_cab", 32'(bus.cab_req), 0);
    bus.f = 3'b101; bus.u = 3'b100; bus.d = 3'b001;
    tick(1); bus.f = '0; bus.u = '0; bus.d = '0;
    tick(3);
    check("clrwin_cab", 32'(bus.cab_req), 32'b100);
    check("ign_up", 32'(bus.up_req), 0);
    check("ign_dn", 32'(bus.dn_req), 0);
    tick(2);
    check("clrwin_cab2", 32'(bus.cab_req), 32'b100);
    // sensor handling
    bus.door_open = 1'b0; bus.s = 3'b100;
    tick(1); bus.s = '0;
    tick(3);
    check("s2_cur", 32'(bus.cur_floor), 2);
    check("s2_err", 32'(bus.sensor_err), 0);
    bus.s = 3'b011;
    tick(1); bus.s = '0;
    tick(3);
    check("multi_cur", 32'(bus.cur_floor), 2);
    check("multi_err", 32'(bus.sensor_err), 1);
    bus.s = 3'b010;
    tick(1); bus.s = '0;
    tick(3);
    check("s1_cur", 32'(bus.cur_floor), 1);
    check("err_sticky", 32'(bus.sensor_err), 1);
    // async reset mid-operation
    bus.f = 3'b010; bus.u = 3'b010;
    tick(1); bus.f = '0; bus.u = '0;
    tick(3);
    check("pre_cab", 32'(bus.cab_req), 32'b110);
    check("pre_up", 32'(bus.up_req), 32'b010);
    check("pre_here", 32'(bus.req_here), 1);
    #2 rst = 1'b1;
    #1;
    check("ar_cab", 32'(bus.cab_req), 0);
    check("ar_up", 32'(bus.up_req), 0);
    check("ar_cur", 32'(bus.cur_floor), 0);
    check("ar_err", 32'(bus.sensor_err), 0);
    check("ar_sum", {29'd0, bus.req_above, bus.req_below, bus.req_here}, 0);
    #49 rst = 1'b0;
    tick(2);
    check("post_cab", 32'(bus.cab_req), 0);
    check("post_up", 32'(bus.up_req), 0);
    check("post_cur", 32'(bus.cur_floor), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/elevator_request_latch.md
Name: elevator_request_latch

Overview:
- Upstream front-end of the elevator controller.
- Synchronises the raw hall buttons (up/down), cabin buttons and floor-sensor pulses, then latches each press as a pending request.
- Tracks the current floor from the sensor pulses. Clears a request once the controller serves it (door open at that floor, compatible direction).
- Feeds the controller clean, level-held request vectors plus above/below/here summaries.

Parameters:
- NUM_FLOORS, 3, number of floors; index 0 is the ground floor.
- FLOOR_W, 2, width of the floor index; must satisfy 2**FLOOR_W >= NUM_FLOORS.
- SYNC_STAGES, 2, flops in each input synchroniser; minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s  in  NUM_FLOORS  floor sensors; bit i pulses on arrival at floor i.
- f  in  NUM_FLOORS  cabin floor buttons.
- u  in  NUM_FLOORS  hall up buttons.
- d  in  NUM_FLOORS  hall down buttons.
- ac  in  2  motor action from the controller.
- door_open  in  1  door-open flag from the controller.
- cab_req  out  NUM_FLOORS  pending cabin requests.
- up_req  out  NUM_FLOORS  pending hall-up requests.
- dn_req  out  NUM_FLOORS  pending hall-down requests.
- cur_floor  out  FLOOR_W  current floor index.
- req_above  out  1  any pending request at an index greater than cur_floor.
- req_below  out  1  any pending request at an index less than cur_floor.
- req_here  out  1  any pending request at cur_floor.
- sensor_err  out  1  sticky flag: multiple sensors fired in the same cycle.

Behaviour:
- Reset (asynchronous, active-high) clears all state:
  - cab_req/up_req/dn_req = 0, cur_floor = 0, sensor_err = 0, dir = IDLE, all synchroniser and edge flops = 0.
  - Summary outputs are therefore 0.
  - Reset mid-travel discards every pending request; cur_floor returns to 0 regardless of sensor state.
- Input conditioning:
  - Every bit of s/f/u/d passes through SYNC_STAGES flops, then a rising-edge detector: edge = sync_out & ~prev.
  - Input pulses must be high for at least one clk period. Holding a button generates exactly one edge.
  - u[NUM_FLOORS-1] and d[0] are ignored (tied low after sync); those up/dn_req bits are always 0.
- Latency: an input first sampled high at edge k sets its request bit at edge k+SYNC_STAGES+1. This is 3 cycles with default parameters.
- Floor tracking:
  - When exactly one s edge (index i) occurs in a cycle: cur_floor <= i on that edge.
  - Zero edges: hold.
  - Two or more edges: hold cur_floor and set sensor_err. sensor_err clears only on rst.
- Direction register dir, with states IDLE, UP, DOWN:
  - ac = AC_UP → UP.
  - ac = AC_DOWN → DOWN.
  - ac = AC_STOP with no pending requests → IDLE.
  - Otherwise hold. ac = 2'b11 is treated as AC_STOP.
- Serve/clear: while door_open = 1, at floor c = cur_floor:
  - cab_req[c] is cleared.
  - up_req[c] is cleared if dir is UP or IDLE.
  - dn_req[c] is cleared if dir is DOWN or IDLE.
  - At floor 0, up_req[0] is cleared regardless of dir; at the top floor, dn_req[top] is cleared regardless of dir.
- Simultaneous set and clear of the same bit: clear wins. A press at the served floor while the door is open is considered served.
- Set of one bit and clear of a different bit in the same cycle are independent.
- Re-pressing an already pending request has no effect.
- Summary outputs are combinational from the registered request vectors and cur_floor:
  - req_here = cab_req[c] | up_req[c] | dn_req[c].
  - req_above / req_below = OR of all three vectors over indices strictly above / below c.

Decomposition:
- Shared package elevator_pkg:
  - AC_STOP = 2'b00, AC_UP = 2'b01, AC_DOWN = 2'b10.
  - dir_t enum {DIR_IDLE, DIR_UP, DIR_DOWN}.
  - Default NUM_FLOORS / FLOOR_W constants, which the elevator controller also imports.
- One sub-module, sync_edge_detect: parameterised width and stage count, giving a synchroniser plus a one-cycle rising-edge pulse. Instantiated four times (s, f, u, d).

Test Plan:
- Reset, then u[1] high for 1 cycle → up_req = 3'b010 exactly 3 cycles later; req_above = 1, cur_floor = 0.
- Then s[1] for 1 cycle with door_open = 1 and ac = AC_STOP → cur_floor = 1, then up_req = 0 on the next edge; req_here returns to 0.
- From floor 1, f[0] and d[2] pressed together with ac = AC_UP → cab_req = 3'b001, dn_req = 3'b100, req_above = 1, req_below = 1. Then s[2] edge with door_open → dn_req[2] is cleared (top floor) and cab_req stays 3'b001.
- At floor 0 with door_open = 1 held, press f[0] → cab_req[0] never rises (clear wins). Press u[2] or d[0] → no request bits set.
- s = 3'b011 pulsed for 1 cycle → cur_floor unchanged, sensor_err = 1 and stays set until rst.
- Set cab_req = 3'b110 and up_req[1], assert rst for 50 time units mid-operation → all request outputs 0 and cur_floor = 0 immediately on rst rise, without waiting for clk; still 0 after release.
